load_store_unit: RTL and testbench

//  Sits directly upstream of the word-addressed data memory and is its only master. Accepts

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of a word-addressed data memory. Converts
// byte-addressed load/store requests into word reads, lane extraction and
// read-modify-write cycles, rejecting misaligned, illegal or out-of-range ones.
module load_store_unit #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        req_bad_s;
    logic [31:0] req_idx_s;

    // Pick the addressed lane out of a word and zero/sign-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    // Overlay right-aligned store data onto the addressed lane of a word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] mask;
        case (size)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        store_merge = (word & ~(mask << {off, 3'b000})) |
                      ((data & mask) << {off, 3'b000});
    endfunction

    // Request validity check and word index for the incoming request.
    always_comb begin
        req_bad_s = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                    ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
        req_idx_s = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        mem_we_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_bad_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                    end else if (!req_we || (req_size != 2'b10)) begin
                        state_d    = S_READ;
                        mem_addr_d = req_idx_s;
                    end else begin
                        // Full-word store needs no read: go straight to the write.
                        state_d     = S_WRITE;
                        mem_addr_d  = req_idx_s;
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (!we_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(mem_rdata, size_q, signed_q, addr_q[1:0]);
                    resp_err_d   = 1'b0;
                end else begin
                    state_d     = S_WRITE;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    mem_we_d    = 1'b1;
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic checked against a byte-level reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] ref_mem [32];

    load_store_unit #(.DEPTH(32), .IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, synchronous write.
    assign mem_rdata = mem[mem_addr[4:0]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[4:0]] <= mem_wdata;
            we_count <= we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        ref_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                  (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 32);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
        logic [31:0] v;
        v = ref_mem[addr[6:2]] >> (8 * addr[1:0]);
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        logic [7:0] b [4];
        int o;
        o = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) b[i] = ref_mem[addr[6:2]][8*i +: 8];
        for (int i = 0; i < (1 << size); i++) b[o + i] = wdata[8*i +: 8];
        ref_mem[addr[6:2]] = {b[3], b[2], b[1], b[0]};
    endtask

    // One complete request/response transaction with full checking.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int lat, exp_lat, wc0;
        logic e;
        logic [31:0] exp_r;
        e = ref_err(size, addr);
        exp_r = (e || we) ? 32'h0 : ref_load(size, sgn, addr);
        exp_lat = e ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        wc0 = we_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_rdata", resp_rdata, exp_r);
        check("resp_err", {31'h0, resp_err}, {31'h0, e});
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("write_count", 32'(we_count - wc0), (we && !e) ? 32'd1 : 32'd0);
        if (we && !e) ref_store(size, addr, wdata);
        @(negedge clk);
        check("resp_valid_drop", {31'h0, resp_valid}, 32'd0);
        check("idle_mem_bus", mem_addr | mem_wdata | {31'h0, mem_we}, 32'd0);
        if (!e) check("mem_word", mem[addr[6:2]], ref_mem[addr[6:2]]);
    endtask

    initial begin
        int wc0;
        logic [31:0] a;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp", {30'h0, resp_valid, resp_err} | resp_rdata, 32'd0);
        check("rst_mem", mem_addr | mem_wdata | {31'h0, mem_we}, 32'd0);
        rst = 1'b0;

        // Scenarios 1-4: word/byte/half stores and loads, then error cases.
        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_0080);
        check("byte_merge", mem[2], 32'hDEAD_80EF);
        do_req(1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_1234);
        check("half_merge", mem[2], 32'h1234_80EF);
        do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFF_FFFF);
        do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);

        // Scenario 5: stalled response; a competing request must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h08;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0C;
        req_wdata = 32'hA5A5_A5A5;
        wc0 = we_count;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'h0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, ref_mem[2]);
            check("stall_ready", {31'h0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("stall_after_ready", {31'h0, req_ready}, 32'd1);
        check("stall_no_write", 32'(we_count - wc0), 32'd0);

        // Scenario 6: reset during the READ of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h09;
        req_wdata = 32'h55;
        wc0 = we_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_mid_out", mem_addr | mem_wdata | resp_rdata |
                 {30'h0, mem_we, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, req_ready}, 32'd1);
        check("rst_mid_nowrite", 32'(we_count - wc0), 32'd0);
        check("rst_mid_mem", mem[2], ref_mem[2]);
        do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);

        // Random traffic against the reference memory.
        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 33) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < 32; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
